// File: rtl/regfile_pkg.sv
// Shared defaults, address-width helper and register-index type for the
// multi-ported register file with scoreboard.
package regfile_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned NREG_DEF   = 32;

  // Address width for a given register count, never narrower than one bit.
  function automatic int unsigned addr_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  localparam int unsigned AW_DEF = addr_w(NREG_DEF);

  typedef logic [AW_DEF-1:0] reg_idx_t;

  localparam int unsigned REG_ZERO = 0;

endpackage

// File: rtl/regfile_sb_byp.sv
// One read port: write-to-read bypass and readiness for the addressed register.
module regfile_sb_byp
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned AW     = AW_DEF,
  parameter int unsigned NWR    = 2
) (
  input  logic [AW-1:0]         addr,
  input  logic [DATA_W-1:0]     arr_data,
  input  logic                  busy,
  input  logic [NWR-1:0]        we,
  input  logic [NWR*AW-1:0]     waddr,
  input  logic [NWR*DATA_W-1:0] wdata,
  input  logic [NWR-1:0]        wclr,
  output logic [DATA_W-1:0]     data_c,
  output logic                  ready_c
);

  // Later ports overwrite earlier ones, so the highest-index hit wins.
  always_comb begin
    data_c  = arr_data;
    ready_c = !busy;
    for (int p = 0; p < NWR; p++) begin
      if (we[p] && (waddr[p*AW +: AW] == addr)) begin
        data_c = wdata[p*DATA_W +: DATA_W];
        if (wclr[p]) ready_c = 1'b1;
      end
    end
    if (addr == AW'(REG_ZERO)) begin
      data_c  = '0;
      ready_c = 1'b1;
    end
  end

endmodule

// File: rtl/regfile_sb.sv
// Parametrised NRD-read / NWR-write register file with bypass and a per-register
// busy scoreboard used by decode for RAW hazard detection.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned NREG   = NREG_DEF,
  parameter int unsigned NRD    = 2,
  parameter int unsigned NWR    = 2,
  localparam int unsigned AW    = addr_w(NREG)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NRD*AW-1:0]     raddr,
  output logic [NRD*DATA_W-1:0] rdata,
  output logic [NRD-1:0]        rready,
  input  logic [NWR-1:0]        we,
  input  logic [NWR*AW-1:0]     waddr,
  input  logic [NWR*DATA_W-1:0] wdata,
  input  logic [NWR-1:0]        wclr,
  input  logic                  issue_valid,
  input  logic [AW-1:0]         issue_dest,
  input  logic                  flush,
  output logic [NREG-1:0]       busy_vec
);

  if ((NREG < 2) || ((NREG & (NREG - 1)) != 0)) begin : g_bad_nreg
    $error("regfile_sb: NREG must be a power of two and at least 2");
  end
  if ((NRD < 1) || (NRD > 4)) begin : g_bad_nrd
    $error("regfile_sb: NRD must be in 1..4");
  end
  if ((NWR < 1) || (NWR > 2)) begin : g_bad_nwr
    $error("regfile_sb: NWR must be in 1..2");
  end

  logic [DATA_W-1:0] mem [NREG];
  logic [NREG-1:0]   busy_next;

  // Array update; later ports are applied last so they win on a collision.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < NREG; r++) mem[r] <= '0;
    end else begin
      for (int p = 0; p < NWR; p++) begin
        if (we[p] && (waddr[p*AW +: AW] != AW'(REG_ZERO))) begin
          mem[waddr[p*AW +: AW]] <= wdata[p*DATA_W +: DATA_W];
        end
      end
    end
  end

  // Scoreboard priority: flush, then issue, then writeback clear, else hold.
  always_comb begin
    busy_next = busy_vec;
    for (int r = 1; r < NREG; r++) begin
      if (flush) begin
        busy_next[r] = 1'b0;
      end else if (issue_valid && (issue_dest == AW'(r))) begin
        busy_next[r] = 1'b1;
      end else begin
        for (int p = 0; p < NWR; p++) begin
          if (we[p] && wclr[p] && (waddr[p*AW +: AW] == AW'(r))) busy_next[r] = 1'b0;
        end
      end
    end
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) busy_vec <= '0;
    else       busy_vec <= busy_next;
  end

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0] ra;
    assign ra = raddr[i*AW +: AW];

    regfile_sb_byp #(
      .DATA_W (DATA_W),
      .AW     (AW),
      .NWR    (NWR)
    ) u_byp (
      .addr     (ra),
      .arr_data (mem[ra]),
      .busy     (busy_vec[ra]),
      .we       (we),
      .waddr    (waddr),
      .wdata    (wdata),
      .wclr     (wclr),
      .data_c   (rdata[i*DATA_W +: DATA_W]),
      .ready_c  (rready[i])
    );
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard bench for regfile_sb: stimulus queues expected values, a monitor
// on the falling edge pops and compares them against the live outputs.
module tb_regfile_sb;
  import regfile_pkg::*;

  localparam int unsigned DW = 32;
  localparam int unsigned NR = 32;
  localparam int unsigned A  = 5;

  logic            clk;
  logic            reset;
  logic [2*A-1:0]  raddr;
  logic [2*DW-1:0] rdata;
  logic [1:0]      rready;
  logic [1:0]      we;
  logic [2*A-1:0]  waddr;
  logic [2*DW-1:0] wdata;
  logic [1:0]      wclr;
  logic            issue_valid;
  reg_idx_t        issue_dest;
  logic            flush;
  logic [NR-1:0]   busy_vec;

  regfile_sb #(.DATA_W(DW), .NREG(NR), .NRD(2), .NWR(2)) dut (
    .clk         (clk),
    .reset       (reset),
    .raddr       (raddr),
    .rdata       (rdata),
    .rready      (rready),
    .we          (we),
    .waddr       (waddr),
    .wdata       (wdata),
    .wclr        (wclr),
    .issue_valid (issue_valid),
    .issue_dest  (issue_dest),
    .flush       (flush),
    .busy_vec    (busy_vec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // kind 0: rdata[port], kind 1: rready[port], kind 2: busy_vec
  typedef struct {
    int          kind;
    int          port;
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t        e;
      logic [31:0] act;
      e = q.pop_front();
      case (e.kind)
        0:       act = rdata[e.port*DW +: DW];
        1:       act = 32'(rready[e.port]);
        default: act = busy_vec;
      endcase
      total++;
      if (act !== e.exp) begin
        bad++;
        $display("FAIL %s: got %h want %h", e.name, act, e.exp);
      end
    end
  end

  task automatic idle();
    raddr = '0; we = '0; waddr = '0; wdata = '0; wclr = '0;
    issue_valid = 1'b0; issue_dest = '0; flush = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rd(input int port, input int addr);
    raddr[port*A +: A] = A'(addr);
  endtask

  task automatic set_wr(input int port, input int addr, input logic [31:0] d, input logic clr);
    we[port] = 1'b1;
    waddr[port*A +: A] = A'(addr);
    wdata[port*DW +: DW] = d;
    wclr[port] = clr;
  endtask

  task automatic issue(input int addr);
    issue_valid = 1'b1;
    issue_dest = A'(addr);
  endtask

  task automatic exp_rd(input int port, input logic [31:0] d, input string name);
    exp_t e;
    e.kind = 0; e.port = port; e.exp = d; e.name = name;
    q.push_back(e);
  endtask

  task automatic exp_rdy(input int port, input logic r, input string name);
    exp_t e;
    e.kind = 1; e.port = port; e.exp = 32'(r); e.name = name;
    q.push_back(e);
  endtask

  task automatic exp_busy(input logic [31:0] b, input string name);
    exp_t e;
    e.kind = 2; e.port = 0; e.exp = b; e.name = name;
    q.push_back(e);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    reset = 1'b1;
    // Reset is held across ignored activity so it must dominate.
    set_wr(0, 2, 32'hFFFF_FFFF, 1'b0);
    issue(2);
    tick(); tick();
    reset = 1'b0;
    idle();

    exp_busy(32'h0, "reset_busy");
    for (int a = 1; a < 32; a++) begin
      set_rd(0, a);
      set_rd(1, a);
      exp_rd(0, 32'h0, $sformatf("reset_rd0_r%0d", a));
      exp_rd(1, 32'h0, $sformatf("reset_rd1_r%0d", a));
      exp_rdy(0, 1'b1, $sformatf("reset_rdy_r%0d", a));
      tick();
    end

    // Bypass, then array read, then r0 discard.
    idle();
    set_wr(0, 5, 32'hDEAD_BEEF, 1'b0);
    set_rd(1, 5);
    exp_rd(1, 32'hDEAD_BEEF, "byp_r5");
    tick();
    idle();
    set_rd(0, 5);
    exp_rd(0, 32'hDEAD_BEEF, "arr_r5");
    set_wr(0, 0, 32'h1234, 1'b0);
    set_rd(1, 0);
    exp_rd(1, 32'h0, "byp_r0");
    exp_rdy(1, 1'b1, "rdy_r0");
    tick();
    idle();
    set_rd(0, 0);
    exp_rd(0, 32'h0, "arr_r0");
    tick();

    // Same-address collision: higher port wins.
    idle();
    set_wr(0, 7, 32'h11, 1'b0);
    set_wr(1, 7, 32'h22, 1'b0);
    set_rd(0, 7);
    exp_rd(0, 32'h22, "byp_r7_collide");
    tick();
    idle();
    set_rd(1, 7);
    exp_rd(1, 32'h22, "arr_r7_collide");
    tick();

    // Issue r3; same-cycle readiness stays high.
    idle();
    issue(3);
    set_rd(0, 3);
    exp_rdy(0, 1'b1, "issue_same_cycle_rdy");
    tick();
    idle();
    set_rd(0, 3);
    exp_rdy(0, 1'b0, "r3_busy_rdy");
    exp_busy(32'h0000_0008, "r3_busy_vec");
    tick();
    idle();
    set_wr(1, 3, 32'h55, 1'b1);
    set_rd(0, 3);
    exp_rdy(0, 1'b1, "r3_wclr_rdy");
    exp_rd(0, 32'h55, "r3_wclr_data");
    exp_busy(32'h0000_0008, "r3_still_busy");
    tick();
    idle();
    set_rd(0, 3);
    exp_busy(32'h0, "r3_cleared");
    exp_rd(0, 32'h55, "r3_arr");
    exp_rdy(0, 1'b1, "r3_rdy_after");
    tick();

    // Data-only write keeps busy; issue to r0 never sets busy.
    idle();
    issue(8);
    tick();
    idle();
    set_wr(0, 8, 32'hABCD, 1'b0);
    set_rd(1, 8);
    exp_rdy(1, 1'b0, "r8_noclr_rdy");
    exp_rd(1, 32'hABCD, "r8_noclr_data");
    tick();
    idle();
    exp_busy(32'h0000_0100, "r8_still_busy");
    issue(0);
    set_wr(0, 8, 32'hABCD, 1'b1);
    tick();
    idle();
    exp_busy(32'h0, "r8_clr_r0_issue");
    tick();

    // Issue beats same-cycle clear; flush beats issue.
    idle();
    issue(9);
    set_wr(0, 9, 32'h9, 1'b1);
    tick();
    idle();
    exp_busy(32'h0000_0200, "issue_beats_clr");
    flush = 1'b1;
    issue(10);
    tick();
    idle();
    exp_busy(32'h0, "flush_beats_issue");
    tick();

    // Mid-operation reset.
    idle();
    set_wr(0, 4, 32'h99, 1'b0);
    issue(4);
    tick();
    idle();
    set_rd(0, 4);
    exp_rd(0, 32'h99, "r4_before_reset");
    exp_busy(32'h0000_0010, "r4_busy_before_reset");
    tick();
    idle();
    reset = 1'b1;
    set_wr(0, 6, 32'h66, 1'b0);
    tick();
    reset = 1'b0;
    idle();
    set_rd(0, 4);
    set_rd(1, 6);
    exp_rd(0, 32'h0, "r4_after_reset");
    exp_rd(1, 32'h0, "r6_after_reset");
    exp_busy(32'h0, "busy_after_reset");
    tick();

    @(negedge clk);
    #1;
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
